// File: rtl/imem_axil_responder.sv
// Instruction memory behind an AXI4-Lite read-only port, plus a side write port for program load.
// Optional macro IMEM_PROT_CHECK_EN: non-instruction (arprot[2]=0) fetches return SLVERR.
module imem_axil_responder #(
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [XLEN-1:0]   BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_im_arvalid,
  output logic                     o_im_arready,
  input  logic [XLEN-1:0]          i_im_araddr,
  input  logic [2:0]               i_im_arprot,
  output logic                     o_im_rvalid,
  input  logic                     i_im_rready,
  output logic [XLEN-1:0]          o_im_rdata,
  output logic [1:0]               o_im_rresp,
  input  logic                     i_ld_en,
  input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
  input  logic [XLEN-1:0]          i_ld_data
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [XLEN-1:0] MemBytes = XLEN'(DEPTH) << 2;
  localparam logic [1:0]      RespOkay = 2'b00;
  localparam logic [1:0]      RespSlv  = 2'b10;
  localparam logic [1:0]      RespDec  = 2'b11;

  logic [XLEN-1:0] mem_q [DEPTH];

  logic            arready_q, arready_d;
  logic [1:0]      occ_q, occ_d;
  logic            ar_hs, r_hs;

  logic [XLEN-1:0] ar_off;
  logic [AW-1:0]   ar_idx;
  logic [1:0]      ar_resp;
  logic            prot_err;

  logic [XLEN-1:0] rd_word_q;
  logic            stage_vld_q;
  logic [1:0]      stage_resp_q;
  logic [XLEN-1:0] stage_data;

  logic [XLEN-1:0] fifo_data_q [2];
  logic [1:0]      fifo_resp_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;
  logic            fifo_empty, push, pop;

  logic            rvalid;
  logic [XLEN-1:0] head_data;
  logic [1:0]      head_resp;

`ifdef IMEM_PROT_CHECK_EN
  logic unused_prot;
  assign unused_prot = ^i_im_arprot[1:0];
  assign prot_err    = ~i_im_arprot[2];
`else
  logic unused_prot;
  assign unused_prot = ^i_im_arprot;
  assign prot_err    = 1'b0;
`endif

  // Address decode; out-of-range beats alignment and protection faults.
  always_comb begin
    ar_off = i_im_araddr - BASE_ADDR;
    ar_idx = ar_off[AW+1:2];
    if ((i_im_araddr < BASE_ADDR) || (ar_off >= MemBytes)) begin
      ar_resp = RespDec;
    end else if (ar_off[1:0] != 2'b00) begin
      ar_resp = RespSlv;
    end else if (prot_err) begin
      ar_resp = RespSlv;
    end else begin
      ar_resp = RespOkay;
    end
  end

  assign ar_hs = i_im_arvalid & arready_q;
  assign r_hs  = rvalid & i_im_rready;

  // Memory array and its read register carry no reset so contents survive rstn.
  always_ff @(posedge clk) begin
    if (i_ld_en) begin
      mem_q[i_ld_addr] <= i_ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      rd_word_q <= mem_q[ar_idx];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_vld_q  <= 1'b0;
      stage_resp_q <= RespOkay;
    end else begin
      stage_vld_q <= ar_hs;
      if (ar_hs) begin
        stage_resp_q <= ar_resp;
      end
    end
  end

  assign stage_data = (stage_resp_q == RespOkay) ? rd_word_q : '0;

  // The RAM stage lives one cycle; anything not taken straight away parks in the FIFO.
  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign pop        = ~fifo_empty & i_im_rready;
  assign push       = stage_vld_q & ~(fifo_empty & i_im_rready);
  assign fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_resp_q[i] <= RespOkay;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= stage_data;
        fifo_resp_q[wr_ptr_q] <= stage_resp_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({ar_hs, r_hs})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    arready_d = (occ_d < 2'd2);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q     <= 2'd0;
      arready_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      arready_q <= arready_d;
    end
  end

  always_comb begin
    rvalid    = ~fifo_empty | stage_vld_q;
    head_data = fifo_empty ? stage_data : fifo_data_q[rd_ptr_q];
    head_resp = fifo_empty ? stage_resp_q : fifo_resp_q[rd_ptr_q];
  end

  assign o_im_arready = arready_q;
  assign o_im_rvalid  = rvalid;
  assign o_im_rdata   = rvalid ? head_data : '0;
  assign o_im_rresp   = rvalid ? head_resp : RespOkay;

endmodule

// File: tb/tb_imem_axil_responder.sv
// Directed bench for imem_axil_responder at default parameters.
module tb_imem_axil_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_im_arvalid;
  logic        o_im_arready;
  logic [31:0] i_im_araddr;
  logic [2:0]  i_im_arprot;
  logic        o_im_rvalid;
  logic        i_im_rready;
  logic [31:0] o_im_rdata;
  logic [1:0]  o_im_rresp;
  logic        i_ld_en;
  logic [9:0]  i_ld_addr;
  logic [31:0] i_ld_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [0:15];

  always #5 clk = ~clk;

  imem_axil_responder dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_im_arvalid (i_im_arvalid),
    .o_im_arready (o_im_arready),
    .i_im_araddr  (i_im_araddr),
    .i_im_arprot  (i_im_arprot),
    .o_im_rvalid  (o_im_rvalid),
    .i_im_rready  (i_im_rready),
    .o_im_rdata   (o_im_rdata),
    .o_im_rresp   (o_im_rresp),
    .i_ld_en      (i_ld_en),
    .i_ld_addr    (i_ld_addr),
    .i_ld_data    (i_ld_data)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [9:0] a, input logic [31:0] d);
    i_ld_en   = 1'b1;
    i_ld_addr = a;
    i_ld_data = d;
    step();
    i_ld_en   = 1'b0;
  endtask

  // Single fetch from idle with rready high; response expected on the next cycle.
  task automatic rd_one(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                        input logic [31:0] exp_data, input logic [1:0] exp_resp);
    i_im_rready  = 1'b1;
    i_im_arvalid = 1'b1;
    i_im_araddr  = addr;
    i_im_arprot  = prot;
    check({tag, " arready"}, {31'd0, o_im_arready}, 32'd1);
    check({tag, " rvalid early"}, {31'd0, o_im_rvalid}, 32'd0);
    step();
    i_im_arvalid = 1'b0;
    check({tag, " rvalid"}, {31'd0, o_im_rvalid}, 32'd1);
    check({tag, " rdata"}, o_im_rdata, exp_data);
    check({tag, " rresp"}, {30'd0, o_im_rresp}, {30'd0, exp_resp});
    step();
    check({tag, " rvalid done"}, {31'd0, o_im_rvalid}, 32'd0);
  endtask

  initial begin
    rstn         = 1'b1;
    i_im_arvalid = 1'b0;
    i_im_araddr  = '0;
    i_im_arprot  = 3'b100;
    i_im_rready  = 1'b0;
    i_ld_en      = 1'b0;
    i_ld_addr    = '0;
    i_ld_data    = '0;
    #2 rstn = 1'b0;
    step();
    step();
    check("rst arready", {31'd0, o_im_arready}, 32'd0);
    check("rst rvalid", {31'd0, o_im_rvalid}, 32'd0);
    check("rst rdata", o_im_rdata, 32'd0);
    check("rst rresp", {30'd0, o_im_rresp}, 32'd0);
    rstn = 1'b1;
    #1;
    check("release arready low", {31'd0, o_im_arready}, 32'd0);
    step();
    check("release arready high", {31'd1 & 32'd0, o_im_arready}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      model[i] = 32'h1000_0000 + i * 32'h0101_0011;
      ld(10'(i), model[i]);
    end
    model[5] = 32'h0050_0093;
    ld(10'd5, model[5]);
    ld(10'd1023, 32'hDEAD_BEEF);

    rd_one("w5", 32'h14, 3'b100, 32'h0050_0093, 2'b00);
    rd_one("last", 32'hFFC, 3'b100, 32'hDEAD_BEEF, 2'b00);
    rd_one("oor", 32'h1000, 3'b100, 32'd0, 2'b11);
    rd_one("oor high", 32'h8000_0000, 3'b100, 32'd0, 2'b11);
    rd_one("unaligned", 32'h6, 3'b100, 32'd0, 2'b10);
`ifdef IMEM_PROT_CHECK_EN
    rd_one("prot", 32'h0, 3'b000, 32'd0, 2'b10);
`else
    rd_one("prot", 32'h0, 3'b000, model[0], 2'b00);
`endif

    // Back-pressure: two accepted, third held until the first R handshake.
    i_im_rready  = 1'b0;
    i_im_arvalid = 1'b1;
    i_im_araddr  = 32'h0;
    step();
    i_im_araddr  = 32'h4;
    step();
    i_im_araddr  = 32'h8;
    check("bp arready full", {31'd0, o_im_arready}, 32'd0);
    check("bp rdata0", o_im_rdata, model[0]);
    step();
    check("bp arready held", {31'd0, o_im_arready}, 32'd0);
    check("bp rvalid held", {31'd0, o_im_rvalid}, 32'd1);
    check("bp rdata0 stable", o_im_rdata, model[0]);
    i_im_rready = 1'b1;
    step();
    check("bp arready back", {31'd0, o_im_arready}, 32'd1);
    check("bp rdata1", o_im_rdata, model[1]);
    step();
    i_im_arvalid = 1'b0;
    check("bp rdata2", o_im_rdata, model[2]);
    check("bp rvalid2", {31'd0, o_im_rvalid}, 32'd1);
    step();
    check("bp drained", {31'd0, o_im_rvalid}, 32'd0);

    // Streaming: one beat per cycle.
    i_im_rready  = 1'b1;
    i_im_arvalid = 1'b1;
    i_im_araddr  = 32'h0;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("stream rvalid %0d", k), {31'd0, o_im_rvalid}, 32'd1);
      check($sformatf("stream rdata %0d", k), o_im_rdata, model[k]);
      if (k < 7) i_im_araddr = 32'(4 * (k + 1));
      else i_im_arvalid = 1'b0;
    end
    step();
    check("stream done", {31'd0, o_im_rvalid}, 32'd0);

    // Load and fetch of the same word in one cycle returns the old contents.
    i_im_arvalid = 1'b1;
    i_im_araddr  = 32'h24;
    i_ld_en      = 1'b1;
    i_ld_addr    = 10'd9;
    i_ld_data    = 32'hCAFE_0009;
    step();
    i_im_arvalid = 1'b0;
    i_ld_en      = 1'b0;
    check("raw old", o_im_rdata, model[9]);
    step();
    model[9] = 32'hCAFE_0009;
    rd_one("raw new", 32'h24, 3'b100, model[9], 2'b00);

    // Reset with two responses pending.
    i_im_rready  = 1'b0;
    i_im_arvalid = 1'b1;
    i_im_araddr  = 32'h0;
    step();
    i_im_araddr  = 32'h4;
    step();
    i_im_arvalid = 1'b0;
    check("pre-rst rvalid", {31'd0, o_im_rvalid}, 32'd1);
    rstn = 1'b0;
    #1;
    check("mid-rst rvalid", {31'd0, o_im_rvalid}, 32'd0);
    check("mid-rst arready", {31'd0, o_im_arready}, 32'd0);
    step();
    rstn = 1'b1;
    #1;
    check("post-rst arready low", {31'd0, o_im_arready}, 32'd0);
    i_im_rready = 1'b1;
    step();
    check("post-rst arready", {31'd0, o_im_arready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("no stale %0d", k), {31'd0, o_im_rvalid}, 32'd0);
      step();
    end
    rd_one("retained", 32'h14, 3'b100, 32'h0050_0093, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_axil_responder.md
IMEM_AXIL_RESPONDER -- requirements
Module: imem_axil_responder

Interface
REQ-001 Parameter XLEN, default 32, data and address width in bits.
REQ-002 Parameter DEPTH, default 1024, memory size in XLEN-bit words; power of two.
REQ-003 Parameter BASE_ADDR, default 0, byte address of word 0.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 i_im_arvalid  input  1  read-address valid from fetch unit.
REQ-007 o_im_arready  output  1  read-address ready.
REQ-008 i_im_araddr  input  XLEN  byte fetch address.
REQ-009 i_im_arprot  input  3  access protection; bit 2 set means instruction access.
REQ-010 o_im_rvalid  output  1  read-data valid.
REQ-011 i_im_rready  input  1  read-data ready.
REQ-012 o_im_rdata  output  XLEN  instruction word.
REQ-013 o_im_rresp  output  2  response: 00 OKAY, 10 SLVERR, 11 DECERR.
REQ-014 i_ld_en  input  1  program-load write strobe.
REQ-015 i_ld_addr  input  clog2(DEPTH)  program-load word index.
REQ-016 i_ld_data  input  XLEN  program-load word.

Function
REQ-017 AR handshake occurs on a rising edge with i_im_arvalid and o_im_arready both high; R handshake likewise with o_im_rvalid and i_im_rready.
REQ-018 Word index = (i_im_araddr - BASE_ADDR) >> 2; memory read is synchronous, one cycle.
REQ-019 Response for an AR accepted in cycle N is presented on o_im_rvalid no earlier than cycle N+1.
REQ-020 Responses return strictly in AR acceptance order.
REQ-021 Occupancy counter (0..2) counts accepted ARs whose R handshake has not completed; +1 on AR handshake, -1 on R handshake, unchanged when both occur in the same cycle.
REQ-022 o_im_arready is registered and equals (next occupancy < 2); an AR is never accepted when 2 responses are pending.
REQ-023 Response storage is a 2-entry FIFO plus RAM output stage; with i_im_rready held high, one response per cycle sustained.
REQ-024 o_im_rvalid, once high, stays high with o_im_rdata/o_im_rresp stable until R handshake.
REQ-025 Address at or beyond BASE_ADDR + 4*DEPTH, or below BASE_ADDR: rresp DECERR, rdata 0.
REQ-026 i_im_araddr[1:0] nonzero and in range: rresp SLVERR, rdata 0; DECERR takes priority over SLVERR.
REQ-027 i_ld_en writes i_ld_data to word i_ld_addr at the rising edge; load writes do not stall AR or R.
REQ-028 Load and AR read of the same word in one cycle: read returns the old contents.
REQ-029 i_im_arprot otherwise ignored unless IMEM_PROT_CHECK_EN (REQ-034).

Reset
REQ-030 While rstn low: o_im_arready 0, o_im_rvalid 0, o_im_rdata 0, o_im_rresp 00, occupancy 0, FIFO empty.
REQ-031 o_im_arready rises on the first rising edge after rstn deasserts.
REQ-032 Reset mid-transaction discards all pending responses; no R beat is issued for them afterwards.
REQ-033 Memory contents are not affected by reset.

Configuration
REQ-034 Macro IMEM_PROT_CHECK_EN: when defined, an in-range, aligned AR with i_im_arprot[2] = 0 returns SLVERR with rdata 0; when undefined, arprot is ignored and such reads return OKAY with memory data.

Verification
REQ-035 Load word 5 = 0x00500093, AR addr 0x14 arprot 100, rready high -> rvalid next cycle, rdata 0x00500093, rresp 00.
REQ-036 rready low, issue ARs 0x0, 0x4, 0x8 back-to-back -> first two accepted, arready low for third until first R handshake; data returned in order.
REQ-037 AR addr 4*DEPTH (0x1000 at defaults) -> rresp 11, rdata 0; AR addr 0x6 -> rresp 10, rdata 0.
REQ-038 rready high, 8 consecutive ARs 0x0..0x1C -> 8 R beats on 8 consecutive cycles, no bubbles after first.
REQ-039 Two ARs pending, pulse rstn low -> rvalid 0 immediately, arready 0, no stale R beat after release; arready 1 one edge later.
REQ-040 With IMEM_PROT_CHECK_EN, AR 0x0 arprot 000 -> rresp 10; without it -> rresp 00, memory data.
